// File: rtl/writeback_buffer.sv
// In-order write-back FIFO feeding a registered register-bank write port, with read-operand forwarding.
// Latency: 2 edges minimum from push to RegWrite strobe (push edge, then pop edge into the output register).
// Backpressure: in_ready = !full; stall_wb holds the drain while pushes continue until full.
module writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     stall_wb,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        reg3,
    output logic [DATA_W-1:0]        dataToWrite,
    input  logic [ADDR_W-1:0]        fwd_addr1,
    input  logic [ADDR_W-1:0]        fwd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] idx;

    assign count    = cnt_q;
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && !stall_wb;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt_q       <= '0;
            RegWrite    <= 1'b0;
            reg3        <= '0;
            dataToWrite <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                RegWrite    <= 1'b1;
                reg3        <= mem[rd_ptr].addr;
                dataToWrite <= mem[rd_ptr].data;
            end else begin
                RegWrite    <= 1'b0;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define which slots are live.
    always_ff @(posedge clock) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= '{addr: in_addr, data: in_data};
        end
    end

    // Scan oldest-to-youngest so later matches override earlier ones; the
    // output register is the oldest write of all.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        idx       = rd_ptr;
        if (RegWrite && reg3 == fwd_addr1) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = dataToWrite;
        end
        if (RegWrite && reg3 == fwd_addr2) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = dataToWrite;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < cnt_q) begin
                if (mem[idx].addr == fwd_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = mem[idx].data;
                end
                if (mem[idx].addr == fwd_addr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = mem[idx].data;
                end
            end
        end
    end
endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: directed vector table for the documented scenarios, then random traffic
// checked every cycle against a queue-based reference model.
module tb_writeback_buffer;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_addr;
    logic [15:0] in_data;
    logic        stall_wb;
    logic        RegWrite;
    logic [2:0]  reg3;
    logic [15:0] dataToWrite;
    logic [2:0]  fwd_addr1, fwd_addr2;
    logic        fwd_hit1, fwd_hit2;
    logic [15:0] fwd_data1, fwd_data2;
    logic [2:0]  count;
    logic        full, empty;

    always #5 clock = ~clock;

    writeback_buffer #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .stall_wb(stall_wb),
        .RegWrite(RegWrite), .reg3(reg3), .dataToWrite(dataToWrite),
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count), .full(full), .empty(empty)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_strobe = 0;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } ent_t;

    ent_t        mq [$];
    bit          m_rw;
    logic [2:0]  m_r3;
    logic [15:0] m_wd;

    typedef struct {
        bit rst_n, vld; logic [2:0] a; logic [15:0] d; bit st;
        logic [2:0] f1, f2;
        int cnt; bit rdy, rw; logic [2:0] r3; logic [15:0] wd;
        bit h1; logic [15:0] fd1; bit h2; logic [15:0] fd2;
    } vec_t;

    vec_t tv [23];

    function automatic vec_t mk(bit rst_n, bit vld, logic [2:0] a, logic [15:0] d, bit st,
                                logic [2:0] f1, logic [2:0] f2, int cnt, bit rdy, bit rw,
                                logic [2:0] r3, logic [15:0] wd, bit h1, logic [15:0] fd1,
                                bit h2, logic [15:0] fd2);
        vec_t v;
        v.rst_n = rst_n; v.vld = vld; v.a = a; v.d = d; v.st = st; v.f1 = f1; v.f2 = f2;
        v.cnt = cnt; v.rdy = rdy; v.rw = rw; v.r3 = r3; v.wd = wd;
        v.h1 = h1; v.fd1 = fd1; v.h2 = h2; v.fd2 = fd2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: newest matching pending write wins, else the presented strobe, else nothing.
    task automatic mfwd(input logic [2:0] a, output bit h, output logic [15:0] d);
        h = 1'b0;
        d = 16'h0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr == a) begin
                h = 1'b1;
                d = mq[i].data;
                return;
            end
        end
        if (m_rw && m_r3 == a) begin
            h = 1'b1;
            d = m_wd;
        end
    endtask

    task automatic model_check();
        bit h;
        logic [15:0] d;
        chk("count", {29'b0, count}, mq.size());
        chk("full", {31'b0, full}, (mq.size() == DEPTH) ? 1 : 0);
        chk("empty", {31'b0, empty}, (mq.size() == 0) ? 1 : 0);
        chk("in_ready", {31'b0, in_ready}, (mq.size() < DEPTH) ? 1 : 0);
        chk("RegWrite", {31'b0, RegWrite}, {31'b0, m_rw});
        chk("reg3", {29'b0, reg3}, {29'b0, m_r3});
        chk("dataToWrite", {16'b0, dataToWrite}, {16'b0, m_wd});
        mfwd(fwd_addr1, h, d);
        chk("fwd_hit1", {31'b0, fwd_hit1}, {31'b0, h});
        chk("fwd_data1", {16'b0, fwd_data1}, {16'b0, d});
        mfwd(fwd_addr2, h, d);
        chk("fwd_hit2", {31'b0, fwd_hit2}, {31'b0, h});
        chk("fwd_data2", {16'b0, fwd_data2}, {16'b0, d});
        if (RegWrite === 1'b1) n_strobe++;
    endtask

    task automatic model_update();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        if (!reset_n) begin
            mq.delete();
            m_rw = 1'b0;
            m_r3 = 3'h0;
            m_wd = 16'h0;
        end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = (mq.size() > 0) && !stall_wb;
            if (do_pop) begin
                e = mq.pop_front();
                m_rw = 1'b1;
                m_r3 = e.addr;
                m_wd = e.data;
            end else begin
                m_rw = 1'b0;
            end
            if (do_push) mq.push_back(ent_t'{addr: in_addr, data: in_data});
        end
    endtask

    task automatic run_cycle();
        @(negedge clock);
        model_check();
        @(posedge clock);
        model_update();
        #1;
    endtask

    initial begin
        //         rst vld a  data      st f1 f2 cnt rdy rw r3 wd        h1 fd1       h2 fd2
        tv[0]  = mk(0, 1, 5, 16'h1234, 0, 5, 0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        tv[1]  = mk(1, 1, 5, 16'h1234, 0, 5, 0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        tv[2]  = mk(1, 0, 0, 16'h0000, 0, 5, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0000);
        tv[3]  = mk(1, 0, 0, 16'h0000, 0, 5, 0, 0, 1, 1, 5, 16'h1234, 1, 16'h1234, 0, 16'h0000);
        tv[4]  = mk(1, 0, 0, 16'h0000, 0, 5, 0, 0, 1, 0, 5, 16'h1234, 0, 16'h0000, 0, 16'h0000);
        tv[5]  = mk(1, 1, 1, 16'hA001, 1, 1, 5, 0, 1, 0, 5, 16'h1234, 0, 16'h0000, 0, 16'h0000);
        tv[6]  = mk(1, 1, 2, 16'hA002, 1, 1, 2, 1, 1, 0, 5, 16'h1234, 1, 16'hA001, 0, 16'h0000);
        tv[7]  = mk(1, 1, 3, 16'hA003, 1, 2, 3, 2, 1, 0, 5, 16'h1234, 1, 16'hA002, 0, 16'h0000);
        tv[8]  = mk(1, 1, 4, 16'hA004, 1, 3, 4, 3, 1, 0, 5, 16'h1234, 1, 16'hA003, 0, 16'h0000);
        tv[9]  = mk(1, 1, 6, 16'hB006, 1, 6, 4, 4, 0, 0, 5, 16'h1234, 0, 16'h0000, 1, 16'hA004);
        tv[10] = mk(1, 0, 0, 16'h0000, 1, 6, 1, 4, 0, 0, 5, 16'h1234, 0, 16'h0000, 1, 16'hA001);
        tv[11] = mk(1, 0, 0, 16'h0000, 0, 2, 5, 4, 0, 0, 5, 16'h1234, 1, 16'hA002, 0, 16'h0000);
        tv[12] = mk(1, 0, 0, 16'h0000, 0, 1, 4, 3, 1, 1, 1, 16'hA001, 1, 16'hA001, 1, 16'hA004);
        tv[13] = mk(1, 0, 0, 16'h0000, 0, 2, 1, 2, 1, 1, 2, 16'hA002, 1, 16'hA002, 0, 16'h0000);
        tv[14] = mk(1, 0, 0, 16'h0000, 0, 3, 4, 1, 1, 1, 3, 16'hA003, 1, 16'hA003, 1, 16'hA004);
        tv[15] = mk(1, 0, 0, 16'h0000, 0, 4, 6, 0, 1, 1, 4, 16'hA004, 1, 16'hA004, 0, 16'h0000);
        tv[16] = mk(1, 0, 0, 16'h0000, 0, 4, 6, 0, 1, 0, 4, 16'hA004, 0, 16'h0000, 0, 16'h0000);
        tv[17] = mk(1, 1, 3, 16'h0011, 1, 3, 4, 0, 1, 0, 4, 16'hA004, 0, 16'h0000, 0, 16'h0000);
        tv[18] = mk(1, 1, 3, 16'h0022, 1, 3, 7, 1, 1, 0, 4, 16'hA004, 1, 16'h0011, 0, 16'h0000);
        tv[19] = mk(1, 1, 7, 16'h0033, 1, 3, 7, 2, 1, 0, 4, 16'hA004, 1, 16'h0022, 0, 16'h0000);
        tv[20] = mk(0, 1, 5, 16'h0055, 1, 3, 7, 3, 1, 0, 4, 16'hA004, 1, 16'h0022, 1, 16'h0033);
        tv[21] = mk(1, 0, 0, 16'h0000, 0, 3, 7, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        tv[22] = mk(1, 0, 0, 16'h0000, 0, 3, 7, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);

        reset_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; stall_wb = 1'b0;
        fwd_addr1 = '0; fwd_addr2 = '0;
        @(posedge clock);
        model_update();
        #1;

        for (int i = 0; i < 23; i++) begin
            reset_n = tv[i].rst_n; in_valid = tv[i].vld; in_addr = tv[i].a; in_data = tv[i].d;
            stall_wb = tv[i].st; fwd_addr1 = tv[i].f1; fwd_addr2 = tv[i].f2;
            @(negedge clock);
            chk($sformatf("r%0d_count", i), {29'b0, count}, tv[i].cnt);
            chk($sformatf("r%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tv[i].rdy});
            chk($sformatf("r%0d_RegWrite", i), {31'b0, RegWrite}, {31'b0, tv[i].rw});
            chk($sformatf("r%0d_reg3", i), {29'b0, reg3}, {29'b0, tv[i].r3});
            chk($sformatf("r%0d_dataToWrite", i), {16'b0, dataToWrite}, {16'b0, tv[i].wd});
            chk($sformatf("r%0d_fwd_hit1", i), {31'b0, fwd_hit1}, {31'b0, tv[i].h1});
            chk($sformatf("r%0d_fwd_data1", i), {16'b0, fwd_data1}, {16'b0, tv[i].fd1});
            chk($sformatf("r%0d_fwd_hit2", i), {31'b0, fwd_hit2}, {31'b0, tv[i].h2});
            chk($sformatf("r%0d_fwd_data2", i), {16'b0, fwd_data2}, {16'b0, tv[i].fd2});
            model_check();
            @(posedge clock);
            model_update();
            #1;
        end

        // Back-to-back pushes with the drain open: occupancy never builds and every push strobes.
        n_strobe = 0;
        for (int i = 0; i < 12; i++) begin
            reset_n = 1'b1; stall_wb = 1'b0;
            in_valid = (i < 10); in_addr = 3'(i); in_data = 16'hC000 + 16'(i);
            fwd_addr1 = 3'(i); fwd_addr2 = 3'(i + 7);
            @(negedge clock);
            chk("stream_count_le1", {31'b0, (count <= 3'd1)}, 1);
            model_check();
            @(posedge clock);
            model_update();
            #1;
        end
        chk("stream_strobes", n_strobe, 10);

        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            stall_wb  = ($urandom_range(0, 9) < 3);
            in_addr   = 3'($urandom);
            in_data   = 16'($urandom);
            fwd_addr1 = 3'($urandom);
            fwd_addr2 = 3'($urandom);
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
